// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, width codes and request helpers for the LSU memory port
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    localparam int LSU_READ_LATENCY  = 2;
    localparam int LSU_WRITE_LATENCY = 2;

    // Unsigned widths only exist for loads; every other code is illegal.
    function automatic logic lsu_req_err(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (funct3)
            LSU_B:   err = 1'b0;
            LSU_H:   err = addr_lo[0];
            LSU_W:   err = (addr_lo != 2'b00);
            LSU_BU:  err = we;
            LSU_HU:  err = we || addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [3:0] lsu_bytesel(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] sel;
        case (funct3)
            LSU_B, LSU_BU: sel = 4'b0001 << addr_lo;
            LSU_H, LSU_HU: sel = 4'b0011 << addr_lo;
            default:       sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] lsu_lane_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3)
            LSU_B, LSU_BU: d = {4{wdata[7:0]}};
            LSU_H, LSU_HU: d = {2{wdata[15:0]}};
            default:       d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - lane select and sign/zero extension of MMU read data
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = rdata_i;
        case (funct3_i)
            LSU_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  data_o = {24'd0, byte_sel};
            LSU_H:   data_o = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - single-outstanding load/store port between the CU and the MMU
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY  = LSU_READ_LATENCY,
    parameter int WRITE_LATENCY = LSU_WRITE_LATENCY
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [6:0]  CU_address,
    output logic [3:0]  CU_bytesel,
    output logic [31:0] CU_dat_in,
    output logic        read_or_write,
    output logic        retrieve,
    input  logic [31:0] MMU_dat_out
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [6:0]       cu_address_q;
    logic [3:0]       cu_bytesel_q;
    logic [31:0]      cu_dat_in_q;
    logic             read_or_write_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    logic             accept;
    logic             req_bad;
    logic             wait_done;
    logic [31:0]      load_data;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign req_bad   = lsu_req_err(req_we, req_funct3, req_addr[1:0]);
    assign wait_done = (state_q == ST_WAIT) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = req_bad ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                // WAIT spans exactly LATENCY cycles: count LATENCY-1 down to 0.
                state_d = ST_WAIT;
                cnt_d   = we_q ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (MMU_dat_out),
        .data_o    (load_data)
    );

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            we_q            <= 1'b0;
            funct3_q        <= 3'd0;
            addr_lo_q       <= 2'd0;
            cu_address_q    <= 7'd0;
            cu_bytesel_q    <= 4'd0;
            cu_dat_in_q     <= 32'd0;
            read_or_write_q <= 1'b0;
            rsp_rdata_q     <= 32'd0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q      <= req_we;
                funct3_q  <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                if (!req_bad) begin
                    cu_address_q    <= {req_addr[6:2], 2'b00};
                    cu_bytesel_q    <= lsu_bytesel(req_funct3, req_addr[1:0]);
                    cu_dat_in_q     <= lsu_lane_data(req_funct3, req_wdata);
                    read_or_write_q <= req_we;
                end else begin
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b1;
                end
            end
            if (wait_done) begin
                rsp_rdata_q <= we_q ? 32'd0 : load_data;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign retrieve      = (state_q == ST_ISSUE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign CU_address    = cu_address_q;
    assign CU_bytesel    = cu_bytesel_q;
    assign CU_dat_in     = cu_dat_in_q;
    assign read_or_write = read_or_write_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed self-checking bench for lsu_mem_port
module tb_lsu_mem_port;

    logic        soc_clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [6:0]  req_addr = 7'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [6:0]  CU_address;
    logic [3:0]  CU_bytesel;
    logic [31:0] CU_dat_in;
    logic        read_or_write;
    logic        retrieve;
    logic [31:0] MMU_dat_out = 32'd0;

    int total = 0;
    int bad = 0;
    int rsp_pulses = 0;

    int          lat, nret;
    logic [6:0]  c_addr;
    logic [3:0]  c_sel;
    logic [31:0] c_dat;
    logic        c_rw;
    logic [31:0] r_data;
    logic        r_err;
    logic [6:0]  addr_at_rsp;

    lsu_mem_port dut (
        .soc_clk       (soc_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .CU_address    (CU_address),
        .CU_bytesel    (CU_bytesel),
        .CU_dat_in     (CU_dat_in),
        .read_or_write (read_or_write),
        .retrieve      (retrieve),
        .MMU_dat_out   (MMU_dat_out)
    );

    always #5 soc_clk = ~soc_clk;

    always @(negedge soc_clk) if (rsp_valid) rsp_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is just past a falling edge with the DUT idle; lat counts cycles after acceptance edge T.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [6:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge soc_clk);
        #1 req_valid = 1'b0;
        lat = 0; nret = 0;
        c_addr = '0; c_sel = '0; c_dat = '0; c_rw = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge soc_clk);
            if (retrieve) begin
                nret++;
                c_addr = CU_address; c_sel = CU_bytesel; c_dat = CU_dat_in; c_rw = read_or_write;
            end
            if (rsp_valid) begin
                lat = i; r_data = rsp_rdata; r_err = rsp_err; addr_at_rsp = CU_address;
                break;
            end
        end
    endtask

    initial begin
        int ret_cyc[2];
        int rsp_cyc[2];
        int nr, nv, pulses_before;

        #12;
        chk("reset_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_retrieve", retrieve, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_cu_addr", CU_address, 0);
        @(negedge soc_clk);
        reset = 1'b1;

        // LW 0x08
        MMU_dat_out = 32'hDEADBEEF;
        @(negedge soc_clk);
        issue(1'b0, 3'd2, 7'h08, 32'd0);
        chk("lw_latency", lat, 4);
        chk("lw_nret", nret, 1);
        chk("lw_cu_addr", c_addr, 7'h08);
        chk("lw_bytesel", c_sel, 4'b1111);
        chk("lw_rw", c_rw, 0);
        chk("lw_rdata", r_data, 32'hDEADBEEF);
        chk("lw_err", r_err, 0);
        chk("lw_addr_stable", addr_at_rsp, 7'h08);

        // LB / LBU 0x0B
        MMU_dat_out = 32'h80112233;
        @(negedge soc_clk);
        issue(1'b0, 3'd0, 7'h0B, 32'd0);
        chk("lb_bytesel", c_sel, 4'b1000);
        chk("lb_cu_addr", c_addr, 7'h08);
        chk("lb_rdata", r_data, 32'hFFFFFF80);
        @(negedge soc_clk);
        issue(1'b0, 3'd4, 7'h0B, 32'd0);
        chk("lbu_rdata", r_data, 32'h00000080);

        // LH 0x02 sign extension of upper half
        MMU_dat_out = 32'h80011234;
        @(negedge soc_clk);
        issue(1'b0, 3'd1, 7'h02, 32'd0);
        chk("lh_bytesel", c_sel, 4'b1100);
        chk("lh_rdata", r_data, 32'hFFFF8001);

        // SH 0x12
        @(negedge soc_clk);
        issue(1'b1, 3'd1, 7'h12, 32'h0000ABCD);
        chk("sh_latency", lat, 4);
        chk("sh_cu_addr", c_addr, 7'h10);
        chk("sh_bytesel", c_sel, 4'b1100);
        chk("sh_dat_in", c_dat, 32'hABCDABCD);
        chk("sh_rw", c_rw, 1);
        chk("sh_err", r_err, 0);
        chk("sh_rdata", r_data, 0);

        // SB byte lane replication
        @(negedge soc_clk);
        issue(1'b1, 3'd0, 7'h21, 32'h123456A5);
        chk("sb_bytesel", c_sel, 4'b0010);
        chk("sb_dat_in", c_dat, 32'hA5A5A5A5);

        // Erroneous requests
        @(negedge soc_clk);
        issue(1'b0, 3'd2, 7'h05, 32'd0);
        chk("lw_mis_nret", nret, 0);
        chk("lw_mis_latency", lat, 1);
        chk("lw_mis_err", r_err, 1);
        chk("lw_mis_rdata", r_data, 0);
        @(negedge soc_clk);
        @(negedge soc_clk);
        chk("err_hold", rsp_err, 1);
        issue(1'b1, 3'd4, 7'h00, 32'hFF);
        chk("sbu_nret", nret, 0);
        chk("sbu_latency", lat, 1);
        chk("sbu_err", r_err, 1);
        @(negedge soc_clk);
        issue(1'b0, 3'd1, 7'h03, 32'd0);
        chk("lh_mis_err", r_err, 1);
        @(negedge soc_clk);
        issue(1'b0, 3'd3, 7'h00, 32'd0);
        chk("f3_illegal_err", r_err, 1);

        // Reset during WAIT of a load
        MMU_dat_out = 32'hCAFEF00D;
        @(negedge soc_clk);
        issue(1'b0, 3'd2, 7'h04, 32'd0);
        chk("pre_reset_rdata", r_data, 32'hCAFEF00D);
        @(negedge soc_clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 7'h14;
        @(posedge soc_clk);
        #1 req_valid = 1'b0;
        @(negedge soc_clk);
        chk("rst_pre_retrieve", retrieve, 1);
        @(negedge soc_clk);
        pulses_before = rsp_pulses;
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_cu_addr", CU_address, 0);
        chk("rst_bytesel", CU_bytesel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        repeat (4) @(negedge soc_clk);
        chk("rst_no_rsp", rsp_pulses - pulses_before, 0);
        reset = 1'b1;
        MMU_dat_out = 32'h12345678;
        issue(1'b0, 3'd2, 7'h0C, 32'd0);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_cu_addr", c_addr, 7'h0C);
        chk("post_rst_rdata", r_data, 32'h12345678);

        // Back-to-back LHU with req_valid held high
        MMU_dat_out = 32'h80011234;
        @(negedge soc_clk);
        nr = 0; nv = 0;
        ret_cyc[0] = 0; ret_cyc[1] = 0; rsp_cyc[0] = 0; rsp_cyc[1] = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd5; req_addr = 7'h02;
        for (int i = 1; i <= 14; i++) begin
            @(negedge soc_clk);
            if (retrieve) begin
                if (nr < 2) ret_cyc[nr] = i;
                nr++;
                if (nr == 2) req_valid = 1'b0;
            end
            if (rsp_valid) begin
                if (nv < 2) rsp_cyc[nv] = i;
                nv++;
                chk("b2b_rdata", rsp_rdata, 32'h00008001);
            end
        end
        chk("b2b_nret", nr, 2);
        chk("b2b_nrsp", nv, 2);
        chk("b2b_ret0", ret_cyc[0], 1);
        chk("b2b_rsp0", rsp_cyc[0], 4);
        chk("b2b_ret1", ret_cyc[1], 6);
        chk("b2b_rsp1", rsp_cyc[1], 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter READ_LATENCY, default 2: cycles from the retrieve cycle C to the cycle in which MMU_dat_out holds read data.
REQ-002 Parameter WRITE_LATENCY, default 2: cycles after C before a store is reported complete.
REQ-003 soc_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  CU request valid.
REQ-006 req_ready  out  1  LSU can accept a request.
REQ-007 req_we  in  1  0=load, 1=store.
REQ-008 req_funct3  in  3  RV32 width code: 0=B, 1=H, 2=W, 4=BU, 5=HU.
REQ-009 req_addr  in  7  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-013 rsp_err  out  1  misaligned access or illegal funct3; qualified by rsp_valid.
REQ-014 CU_address  out  7  word address to MMU; bits [1:0] always 0.
REQ-015 CU_bytesel  out  4  byte-lane enables to MMU.
REQ-016 CU_dat_in  out  32  lane-positioned store data.
REQ-017 read_or_write  out  1  0=read, 1=write.
REQ-018 retrieve  out  1  one-cycle memory-op pulse.
REQ-019 MMU_dat_out  in  32  read data from MMU.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on an edge where req_valid && req_ready, capturing we, funct3, addr and wdata; IDLE then moves to ISSUE, or to RESP directly if the request is erroneous.
REQ-022 The request SHALL be erroneous if funct3 is 3, 6 or 7, if a store has funct3 of 4 or 5, if a halfword has addr[0]=1, or if a word has addr[1:0]!=0; an erroneous request issues no retrieve.
REQ-023 In ISSUE (cycle C), retrieve SHALL be 1 for exactly that cycle, with read_or_write=we and CU_address={addr[6:2],2'b00}; the FSM then enters WAIT.
REQ-024 CU_bytesel SHALL be 0001<<addr[1:0] for a byte, 0011<<addr[1:0] for a halfword, and 1111 for a word.
REQ-025 CU_dat_in SHALL be wdata[7:0] replicated to all lanes for a byte, wdata[15:0] replicated twice for a halfword, and wdata for a word.
REQ-026 CU_address, CU_bytesel, CU_dat_in and read_or_write SHALL be registered and held stable from C until the FSM returns to IDLE.
REQ-027 WAIT SHALL count down with a counter of width clog2(max latency)+1, leaving WAIT on the edge ending cycle C+READ_LATENCY (loads) or C+WRITE_LATENCY (stores).
REQ-028 A load SHALL sample MMU_dat_out on the edge that ends WAIT, select the lane by addr[1:0], and sign-extend for B/H or zero-extend for BU/HU.
REQ-029 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE.
REQ-030 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid.
REQ-031 Minimum load turnaround SHALL be acceptance at edge T, retrieve in cycle T+1, and rsp_valid in cycle T+2+READ_LATENCY.
REQ-032 An erroneous request SHALL produce rsp_valid with rsp_err=1 in the cycle after acceptance.
REQ-033 req_valid while busy SHALL be ignored and not queued.

Reset
REQ-034 reset low SHALL asynchronously force state=IDLE, counter=0, and all outputs to 0 except req_ready=1; any in-flight operation is abandoned with no rsp_valid.
REQ-035 Deassertion of reset SHALL be synchronized externally; the LSU SHALL accept a request on the first edge after reset is high.

Structure
REQ-036 Package lsu_pkg SHALL hold the state enum, the funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), and the default latencies.
REQ-037 Load extraction (lane select plus extension) SHALL be a combinational sub-module lsu_load_align; everything else lives in lsu_mem_port.

Verification
REQ-038 LW at addr 0x08, MMU_dat_out=0xDEADBEEF -> retrieve with CU_address=0x08, bytesel=1111, read_or_write=0; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle T+4.
REQ-039 LB at addr 0x0B, MMU_dat_out=0x80112233 -> bytesel=1000, rsp_rdata=0xFFFFFF80; LBU with the same stimulus -> 0x00000080.
REQ-040 SH at addr 0x12, wdata=0x0000ABCD -> CU_address=0x10, bytesel=1100, CU_dat_in=0xABCDABCD, read_or_write=1; rsp_valid after WRITE_LATENCY with rsp_err=0.
REQ-041 LW at addr 0x05 and SB with funct3=4 -> no retrieve pulse; rsp_valid with rsp_err=1 one cycle after acceptance.
REQ-042 reset driven low during WAIT of a load -> outputs 0, req_ready=1 immediately, no rsp_valid; a subsequent LW completes normally.
REQ-043 req_valid held high continuously across two LHU requests at 0x02 -> second accepted only after the first RESP; exactly two retrieve pulses and two rsp_valid pulses.
